// File: rtl/tt_lut_pkg.sv
// Shared types and helpers for the runtime-programmable truth-table gate.
package tt_lut_pkg;

  localparam int MAX_N_IN = 6;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_lut_gate_settle.sv
// Input-settling filter: registers the raw input vector and flags it settled
// once it has held unchanged for STABLE cycles (always settled when STABLE = 0).
module input_settle_filter
  import tt_lut_pkg::*;
#(
  parameter int W      = 3,
  parameter int STABLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  output logic [W-1:0] in_q,
  output logic         settled
);

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [3:0] cnt;
  logic       same;

  assign same = (in == in_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
      cnt  <= '0;
    end else begin
      in_q <= in;
      if (!same) begin
        cnt <= '0;
      end else if (cnt != STABLE_C) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Compare against the registered count so the output lands S+1 edges after in_q.
  assign settled = (STABLE == 0) ? 1'b1 : (same && (cnt == STABLE_C));

endmodule

// File: rtl/tt_lut_gate.sv
// Truth-table gate: evaluates an N_IN-input function from a committed table,
// with a serial valid/ready reload port that commits the new table atomically.
//
// state | meaning
// RUN   | evaluating; load port idle, cfg_ready low
// LOAD  | accepting table bits into the shadow register, index 0 first
module tt_lut_gate
  import tt_lut_pkg::*;
#(
  parameter int                         N_IN     = 3,
  parameter logic [tt_width(N_IN)-1:0]  TT_RESET = 8'h7E,
  parameter int                         STABLE   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  output logic            out,
  output logic            out_valid,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done
);

  localparam int              TT_W = tt_width(N_IN);
  localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

  state_t            state, state_nxt;
  logic [TT_W-1:0]   tbl, tbl_nxt;
  logic [TT_W-1:0]   shadow, shadow_nxt;
  logic [N_IN-1:0]   bcnt, bcnt_nxt;
  logic              done_nxt;
  logic              accept;
  logic [N_IN-1:0]   in_q;
  logic              settled;

  input_settle_filter #(
    .W      (N_IN),
    .STABLE (STABLE)
  ) u_settle (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .in_q    (in_q),
    .settled (settled)
  );

  assign cfg_ready = (state == LOAD);
  assign accept    = cfg_ready & cfg_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      tbl      <= TT_RESET;
      shadow   <= '0;
      bcnt     <= '0;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      tbl      <= tbl_nxt;
      shadow   <= shadow_nxt;
      bcnt     <= bcnt_nxt;
      cfg_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tbl_nxt    = tbl;
    shadow_nxt = shadow;
    bcnt_nxt   = bcnt;
    done_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (cfg_start) begin
          state_nxt  = LOAD;
          shadow_nxt = '0;
          bcnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          shadow_nxt[bcnt] = cfg_bit;
        end
        // The final beat commits even if a restart arrives in the same cycle.
        if (accept && (bcnt == LAST)) begin
          tbl_nxt   = shadow_nxt;
          bcnt_nxt  = '0;
          done_nxt  = 1'b1;
          state_nxt = RUN;
        end else if (cfg_start) begin
          shadow_nxt = '0;
          bcnt_nxt   = '0;
        end else if (accept) begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= settled;
      if (settled) begin
        out <= tbl[in_q];
      end
    end
  end

endmodule

// File: tb/tb_tt_lut_gate.sv
// Self-checking bench for tt_lut_gate: a filtered N_IN=3 instance and an
// unfiltered N_IN=1 instance, checked through a due-cycle scoreboard plus direct checks.
module tb_tt_lut_gate;

  localparam int SA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic [2:0] ina;
  logic       outa, vala, starta, cvalida, cbita, readya, donea;
  logic [0:0] inb;
  logic       outb, valb, readyb, doneb;

  tt_lut_gate #(.N_IN(3), .TT_RESET(8'h7E), .STABLE(SA)) dut_a (
    .clk(clk), .rst(rst), .in(ina), .out(outa), .out_valid(vala),
    .cfg_start(starta), .cfg_valid(cvalida), .cfg_bit(cbita),
    .cfg_ready(readya), .cfg_done(donea)
  );

  tt_lut_gate #(.N_IN(1), .TT_RESET(2'b10), .STABLE(0)) dut_b (
    .clk(clk), .rst(rst), .in(inb), .out(outb), .out_valid(valb),
    .cfg_start(1'b0), .cfg_valid(1'b0), .cfg_bit(1'b0),
    .cfg_ready(readyb), .cfg_done(doneb)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    due;
    bit    inst;
    logic  o;
    logic  v;
    string tag;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [2:0] in;
    logic       exp;
  } vec_t;
  vec_t sweep[8];

  logic       exp_a;
  logic [1:0] tt_b;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int due, input bit inst, input logic o, input logic v,
                      input string tag);
    sb_t e;
    int  k;
    e.due = due; e.inst = inst; e.o = o; e.v = v; e.tag = tag;
    k = sb.size();
    while (k > 0 && sb[k-1].due > due) k--;
    sb.insert(k, e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s_late: due %0d checked at %0d", e.tag, e.due, cyc);
      end else begin
        check({e.tag, "_out"},   e.inst ? outb : outa, e.o);
        check({e.tag, "_valid"}, e.inst ? valb : vala, e.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change in and expect the old value (invalid) until S+1 edges after in_q updates.
  task automatic apply_a(input logic [2:0] v, input logic exp_new);
    int c;
    c = cyc;
    ina = v;
    for (int k = 1; k <= SA + 1; k++) push(c + k, 1'b0, exp_a, 1'b0, $sformatf("hold_in%0d", v));
    push(c + SA + 2, 1'b0, exp_new, 1'b1, $sformatf("eval_in%0d", v));
    exp_a = exp_new;
    repeat (SA + 2) tick();
  endtask

  task automatic send_start();
    starta = 1'b1;
    tick();
    starta = 1'b0;
    check("ready_after_start", readya, 1'b1);
  endtask

  task automatic send_bits(input logic [7:0] val, input int n, input bit commits);
    for (int i = 0; i < n; i++) begin
      cvalida = 1'b1;
      cbita   = val[i];
      tick();
      check($sformatf("done_beat%0d", i), donea, (commits && (i == n - 1)));
    end
    cvalida = 1'b0;
  endtask

  task automatic post_reset_push();
    int r;
    r = cyc;
    push(r + 1, 1'b0, 1'b0, 1'b0, "rst_a1");
    push(r + 2, 1'b0, 1'b0, 1'b0, "rst_a2");
    push(r + 3, 1'b0, 1'b0, 1'b1, "rst_a3");
    push(r + 1, 1'b1, 1'b0, 1'b1, "rst_b1");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] parity;
    sweep[0] = '{3'd1, 1'b1};
    sweep[1] = '{3'd2, 1'b1};
    sweep[2] = '{3'd3, 1'b1};
    sweep[3] = '{3'd4, 1'b1};
    sweep[4] = '{3'd5, 1'b1};
    sweep[5] = '{3'd6, 1'b1};
    sweep[6] = '{3'd7, 1'b0};
    sweep[7] = '{3'd0, 1'b0};
    tt_b    = 2'b10;
    parity  = 8'h96;
    exp_a   = 1'b0;
    rst     = 1'b1;
    ina     = '0;
    inb     = '0;
    starta  = 1'b0;
    cvalida = 1'b0;
    cbita   = 1'b0;

    repeat (3) tick();
    check("reset_out",   outa,   1'b0);
    check("reset_valid", vala,   1'b0);
    check("reset_ready", readya, 1'b0);
    check("reset_done",  donea,  1'b0);
    check("reset_b_valid", valb, 1'b0);
    rst = 1'b0;
    post_reset_push();
    repeat (3) tick();

    for (int i = 0; i < 8; i++) apply_a(sweep[i].in, sweep[i].exp);

    // Glitch to 111 for two cycles must never reach out.
    apply_a(3'd1, 1'b1);
    begin
      int c;
      c = cyc;
      ina = 3'd7;
      for (int k = 1; k <= 5; k++) push(c + k, 1'b0, 1'b1, 1'b0, "glitch");
      push(c + 6, 1'b0, 1'b1, 1'b1, "glitch_end");
      repeat (2) tick();
      ina = 3'd1;
      repeat (4) tick();
    end

    // Reload with parity table while in=111 is held.
    apply_a(3'd7, 1'b0);
    send_start();
    for (int i = 0; i < 8; i++) begin
      cvalida = 1'b1;
      cbita   = parity[i];
      tick();
      check($sformatf("reload_done%0d", i), donea, (i == 7));
      check($sformatf("reload_out%0d", i), outa, 1'b0);
    end
    cvalida = 1'b0;
    tick();
    check("reload_out_new", outa,   1'b1);
    check("reload_valid",   vala,   1'b1);
    check("reload_done_lo", donea,  1'b0);
    check("reload_ready_lo", readya, 1'b0);
    exp_a = 1'b1;

    // Restart mid-load, then commit 8'h01.
    send_start();
    send_bits(8'hFF, 5, 1'b0);
    send_start();
    send_bits(8'h01, 8, 1'b1);
    tick();
    check("restart_out7",   outa,   1'b0);
    check("restart_ready",  readya, 1'b0);
    exp_a = 1'b0;
    apply_a(3'd0, 1'b1);
    apply_a(3'd1, 1'b0);

    // Reset after four beats restores TT_RESET and abandons the load.
    send_start();
    send_bits(8'hFF, 4, 1'b0);
    rst     = 1'b1;
    ina     = 3'd0;
    tick();
    check("midrst_out",   outa,   1'b0);
    check("midrst_valid", vala,   1'b0);
    check("midrst_ready", readya, 1'b0);
    check("midrst_done",  donea,  1'b0);
    rst = 1'b0;
    post_reset_push();
    repeat (3) tick();
    exp_a = 1'b0;
    apply_a(3'd1, 1'b1);
    apply_a(3'd7, 1'b0);
    send_start();
    send_bits(8'hFF, 8, 1'b1);
    tick();
    check("ff_out7",   outa, 1'b1);
    check("ff_valid",  vala, 1'b1);
    check("ff_done_lo", donea, 1'b0);

    // Unfiltered instance: one cycle of latency, single-cycle glitches pass.
    begin
      logic [9:0] seq;
      logic [0:0] v;
      seq = 10'b0011011001;
      for (int i = 0; i < 10; i++) begin
        v = seq[i];
        inb = v;
        push(cyc + 2, 1'b1, tt_b[v], 1'b1, $sformatf("b_step%0d", i));
        tick();
      end
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: %0d expected results never compared", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_lut_gate.md
# tt_lut_gate

Parametrised, runtime-programmable truth-table gate. It evaluates an N_IN-input Boolean function from a 2^N_IN-bit table register, with a registered output and an input-settling filter that suppresses glitches. The table is reloaded serially through a valid/ready port without disturbing evaluation. It sits where fixed per-function gate modules (e.g. m0x7E) were instantiated, and replaces any of them by setting TT_RESET.

## Interface
- N_IN, default 3: number of function inputs, 1..6; table width TT_W = 2^N_IN.
- TT_RESET, default 8'h7E (width TT_W): table loaded on reset. Bit i is the output for input vector i, with {in[N_IN-1],…,in[0]} = i.
- STABLE, default 2: cycles the input vector must stay unchanged before the output follows it, 0..15. 0 disables filtering.
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in, input, N_IN: function inputs. Asynchronous to the function; registered internally.
- out, output, 1: evaluated function value.
- out_valid, output, 1: out corresponds to the current settled input vector and the current table.
- cfg_start, input, 1: one-cycle pulse that begins a table load.
- cfg_valid, input, 1: cfg_bit is valid.
- cfg_bit, input, 1: serial table bit, index 0 first.
- cfg_ready, output, 1: load port is accepting bits.
- cfg_done, output, 1: one-cycle pulse when a new table is committed.

## Operation
- Reset values:
  - table = TT_RESET, shadow = 0, bit counter = 0
  - state RUN; in_q = 0, settle counter = 0
  - out = 0, out_valid = 0, cfg_ready = 0, cfg_done = 0
- Load FSM:
  - RUN → LOAD on cfg_start. In LOAD, cfg_ready = 1.
  - Each cycle with cfg_valid & cfg_ready: shadow[cnt] ← cfg_bit, cnt++.
  - When the bit at index TT_W−1 is accepted: table ← shadow (atomic, full width), cfg_done = 1 next cycle, cnt ← 0, state ← RUN.
  - cfg_start while in LOAD restarts the load: cnt ← 0, shadow cleared, bits already accepted are discarded.
  - If cfg_start coincides with the final accepted bit, the commit wins and cfg_start is ignored.
  - In RUN, cfg_valid is ignored and cfg_ready = 0.
- Evaluation always uses the committed table. Loading never alters out until commit.
- Settle filter:
  - in_q ← in every cycle.
  - If in ≠ in_q: settle counter ← 0, out_valid ← 0, out holds its value.
  - Otherwise the counter increments, saturating at STABLE.
  - When the counter reaches STABLE: out ← table[in_q], out_valid ← 1.
- Commit while settled: out ← new table[in_q] on the cycle after the commit; out_valid stays 1.
- STABLE = 0: out ← table[in_q] every cycle; out_valid = 1 from the second cycle after reset.
- Reset during LOAD discards the shadow and restores TT_RESET. No partial table is ever visible.

## Timing
- Latency, STABLE = S > 0: in changes before edge t and is then held → in_q updates at t → out/out_valid update at edge t+S+1.
- Latency, STABLE = 0: out updates at edge t+1.
- A glitch that lasts fewer than S+1 cycles never reaches out. out_valid drops for the duration of the glitch.
- Load length: TT_W accepted beats. With cfg_valid held high, the commit happens TT_W cycles after the first accepted beat.
  - Example, N_IN = 3: cfg_start at edge 0, beats accepted at edges 1..8, table commits at edge 8, cfg_done is high during cycle 9.
- cfg_done is never high for more than one cycle and is never asserted without a preceding full load.

## Structure
- Package tt_lut_pkg holds:
  - state enum {RUN, LOAD}
  - function tt_width(n) = 1 << n
  - constant MAX_N_IN = 6
- Sub-module input_settle_filter, parameters W and STABLE: holds in_q and the counter, and outputs the settled vector plus a settled flag.
- Load FSM, table/shadow registers and output register live in tt_lut_gate.

## Test plan
- Reset defaults: N_IN = 3, TT_RESET = 8'h7E, STABLE = 2. Sweep in = 000..111, holding each value 4 cycles → out = 0,1,1,1,1,1,1,0, each appearing 3 edges after the input change.
- Glitch rejection: in = 001 settled (out = 1), then pulse in = 111 for 2 cycles, then back to 001 → out stays 1 throughout; out_valid low during the pulse and for 3 edges after it.
- Reload: load 8'h96 (parity) bit 0 first with in = 111 held → out stays 0 until commit, becomes 1 on the cycle after the commit, cfg_done pulses once.
- Load restart: cfg_start, 5 beats of 1s, cfg_start again, then a full load of 8'h01 → table = 8'h01; in = 000 → out = 1, in = 001 → out = 0.
- Reset mid-load: after 4 beats, assert rst for 1 cycle → table = 8'h7E, cfg_ready = 0, out = 0, out_valid = 0; the next full load of 8'hFF commits normally.
- STABLE = 0 and N_IN = 1, TT_RESET = 2'b10 → out tracks in with 1 cycle of latency; a 1-cycle glitch propagates.
